stage2_window_gen: RTL
======================

STAGE2_WINDOW_GEN -- requirements
Module: stage2_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 12: feature-map width in pixels, minimum `KX.
REQ-002 SHALL have parameter IMG_H, default 12: feature-map height in pixels, minimum `KY.
REQ-003 SHALL have parameter WIN_GAP, default 53: minimum spacing in cycles between output windows; 1 means no throttling.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_in_valid, input, 1 bit: upstream pixel valid.
REQ-007 SHALL have port i_in_pixel, input, `ST2_Conv_IBW bits, signed: raster-order pixel (row-major, left to right).
REQ-008 SHALL have port o_in_ready, output, 1 bit: pixel accepted when i_in_valid && o_in_ready.
REQ-009 SHALL have port o_ot_valid, output, 1 bit: one-cycle window strobe to the stage-2 convolution kernel.
REQ-010 SHALL have port o_ot_fmap, output, `KX*`KY*`ST2_Conv_IBW bits, signed: packed 5x5 window.
REQ-011 SHALL have port o_frame_done, output, 1 bit: one-cycle pulse marking the last window of a frame.

Function
REQ-012 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), advanced only on accepted pixels; col wraps to 0 and increments row; at (IMG_H-1, IMG_W-1) both wrap to 0.
REQ-013 SHALL buffer the previous `KY-1 rows in line buffers of depth IMG_W plus a `KY x `KX shift-register window.
REQ-014 SHALL treat an accepted pixel at (row,col) with row>=`KY-1 and col>=`KX-1 as window-producing; all other accepted pixels produce no output.
REQ-015 SHALL assert o_ot_valid exactly 1 cycle after acceptance of a window-producing pixel, with o_ot_fmap holding rows row-4..row and cols col-4..col.
REQ-016 SHALL pack window element (y,x) at bits [(y*`KX+x)*`ST2_Conv_IBW +: `ST2_Conv_IBW], where y=0 is the oldest row and x=0 is the leftmost column.
REQ-017 SHALL hold o_ot_fmap stable until the next o_ot_valid.
REQ-018 SHALL emit exactly (IMG_H-4)*(IMG_W-4) windows per frame, which is 64 at the defaults.
REQ-019 SHALL load gap counter gap_cnt with WIN_GAP-1 on each o_ot_valid and decrement it to 0 each cycle.
REQ-020 SHALL drive o_in_ready low only when gap_cnt!=0 and the next pixel position is window-producing; otherwise o_in_ready SHALL be high.
REQ-021 SHALL guarantee consecutive o_ot_valid pulses are at least WIN_GAP cycles apart.
REQ-022 SHALL assert o_frame_done in the same cycle as the o_ot_valid for pixel (IMG_H-1, IMG_W-1).
REQ-023 SHALL leave all state unchanged on cycles with i_in_valid low; input bubbles SHALL NOT alter the window contents.
REQ-024 SHALL accept the next frame's first pixel in the cycle after the last pixel of the previous frame, with no dead cycles.

Reset
REQ-025 SHALL, while reset_n is low, force o_ot_valid=0, o_frame_done=0, o_ot_fmap=0, row=col=0, gap_cnt=0 and o_in_ready=1.
REQ-026 SHALL, on reset mid-frame, discard the partial frame so the next accepted pixel is (0,0); line-buffer contents need no reset.

Configuration
REQ-027 SHALL, with macro ST2_WIN_DEBUG_EN defined, add outputs o_win_row and o_win_col, each 8 bits, giving the window top-left (row-4, col-4), registered alongside o_ot_valid and reset to 0.
REQ-028 SHALL, without ST2_WIN_DEBUG_EN, omit these ports, with all other behaviour identical.

Structure
REQ-029 SHALL take `KX, `KY and `ST2_Conv_IBW from the shared stage2_defines_cnn_core.v; no local redefinition.
REQ-030 SHALL implement each row buffer as sub-module stage2_line_buffer (depth IMG_W, width `ST2_Conv_IBW, shift on enable), instantiated `KY-1 times.

Verification
REQ-031 SHALL cover: WIN_GAP=1, 144 back-to-back pixels with value=row*12+col -> 64 o_ot_valid, o_in_ready never low; first window element (0,0)=0, element (4,4)=52, element (0,4)=4.
REQ-032 SHALL cover: WIN_GAP=53, same stream -> every o_ot_valid spacing >=53 cycles; last window element (4,4)=143 with o_frame_done asserted together with it.
REQ-033 SHALL cover: random i_in_valid bubbles (about 50% duty) -> window sequence identical to REQ-031.
REQ-034 SHALL cover: reset asserted after 70 accepted pixels, then a full frame -> first window again 0..52 pattern, 64 windows total.
REQ-035 SHALL cover: two back-to-back frames -> 128 windows and 2 o_frame_done pulses; window 65 element (0,0)=0.
REQ-036 SHALL cover: ST2_WIN_DEBUG_EN defined -> first window (o_win_row,o_win_col)=(0,0) and last window (7,7).

Source files
------------

// File: rtl/stage2_window_gen_pkg.sv
// Types and constants shared by the stage-2 window generator and its line buffers.
`include "stage2_defines_cnn_core.v"

package stage2_window_gen_pkg;

    localparam int KX  = `KX;
    localparam int KY  = `KY;
    localparam int IBW = `ST2_Conv_IBW;

    typedef logic signed [IBW-1:0] pixel_t;

    // Packed [y][x] ordering flattens so that element (y,x) sits at (y*KX+x)*IBW.
    typedef logic [KY-1:0][KX-1:0][IBW-1:0] window_t;

    localparam int WIN_BITS = $bits(window_t);

endpackage

// File: rtl/stage2_defines_cnn_core.v
// Shared stage-2 CNN core geometry: kernel size and input pixel width.
`ifndef STAGE2_DEFINES_CNN_CORE_V
`define STAGE2_DEFINES_CNN_CORE_V

`define KX 5
`define KY 5
`define ST2_Conv_IBW 16

`endif

// File: rtl/stage2_line_buffer.sv
// One feature-map row of delay: shifts on enable, output is the pixel DEPTH accepts ago.
module stage2_line_buffer
    import stage2_window_gen_pkg::*;
#(
    parameter int DEPTH = 12,
    parameter int WIDTH = IBW
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/stage2_window_gen.sv
// Raster-stream to KYxKX sliding-window generator with output throttling.
// Optional debug outputs o_win_row/o_win_col enabled by defining ST2_WIN_DEBUG_EN.
module stage2_window_gen
    import stage2_window_gen_pkg::*;
#(
    parameter int IMG_W   = 12,
    parameter int IMG_H   = 12,
    parameter int WIN_GAP = 53
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_in_valid,
    input  logic signed [IBW-1:0]      i_in_pixel,
    output logic                       o_in_ready,
    output logic                       o_ot_valid,
    output logic signed [WIN_BITS-1:0] o_ot_fmap,
    output logic                       o_frame_done
`ifdef ST2_WIN_DEBUG_EN
    ,
    output logic [7:0]                 o_win_row,
    output logic [7:0]                 o_win_col
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int GW = (WIN_GAP > 1) ? $clog2(WIN_GAP) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN0 = CW'(KX - 1);
    localparam logic [RW-1:0] ROW_WIN0 = RW'(KY - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(WIN_GAP - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [GW-1:0] gap_cnt;

    logic producing;
    logic frame_last;
    logic accept;

    logic [KY-1:0][IBW-1:0] tap;
    window_t                win;
    window_t                win_next;

    assign producing  = (row >= ROW_WIN0) && (col >= COL_WIN0);
    assign frame_last = (row == ROW_LAST) && (col == COL_LAST);
    assign o_in_ready = !((gap_cnt != '0) && producing);
    assign accept     = i_in_valid && o_in_ready;

    // tap[0] is the incoming pixel, tap[k] is the same column k rows earlier.
    assign tap[0] = i_in_pixel;

    for (genvar g = 0; g < KY - 1; g++) begin : g_lb
        stage2_line_buffer #(
            .DEPTH (IMG_W),
            .WIDTH (IBW)
        ) u_lb (
            .clk  (clk),
            .en   (accept),
            .din  (tap[g]),
            .dout (tap[g+1])
        );
    end

    always_comb begin
        win_next = win;
        for (int unsigned y = 0; y < KY; y++) begin
            for (int unsigned x = 0; x < KX - 1; x++) begin
                win_next[y][x] = win[y][x+1];
            end
            win_next[y][KX-1] = tap[KY-1-y];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            win <= win_next;
        end
    end

    // The gap counter is loaded in the same edge that raises o_ot_valid so the
    // next window-producing pixel is held off for exactly WIN_GAP-1 further cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row          <= '0;
            col          <= '0;
            gap_cnt      <= '0;
            o_ot_valid   <= 1'b0;
            o_frame_done <= 1'b0;
            o_ot_fmap    <= '0;
`ifdef ST2_WIN_DEBUG_EN
            o_win_row    <= '0;
            o_win_col    <= '0;
`endif
        end else begin
            o_ot_valid   <= 1'b0;
            o_frame_done <= 1'b0;
            if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (producing) begin
                    o_ot_valid   <= 1'b1;
                    o_frame_done <= frame_last;
                    o_ot_fmap    <= win_next;
                    gap_cnt      <= GAP_LOAD;
`ifdef ST2_WIN_DEBUG_EN
                    o_win_row    <= 8'(row - ROW_WIN0);
                    o_win_col    <= 8'(col - COL_WIN0);
`endif
                end
            end
        end
    end

endmodule
